// File: rtl/control_pipe_pkg.sv
// Shared control-bundle definitions for the decode/execute pipeline.
// Bundle layout, bit indices, bubble constant and the decoder's opcode table.
package control_pipe_pkg;

    localparam int unsigned CTRL_W = 9;

    localparam int unsigned CTRL_BRANCH     = 8;
    localparam int unsigned CTRL_MEM_TO_REG = 7;
    localparam int unsigned CTRL_REG_WRITE  = 6;
    localparam int unsigned CTRL_MEM_READ   = 5;
    localparam int unsigned CTRL_MEM_WRITE  = 4;
    localparam int unsigned CTRL_ALU_SRC    = 3;
    localparam int unsigned CTRL_ALUOP_MSB  = 2;
    localparam int unsigned CTRL_ALUOP_LSB  = 0;

    typedef logic [CTRL_W-1:0] ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_OP_R   = 3'd0;
    localparam logic [2:0] ALU_OP_I   = 3'd1;
    localparam logic [2:0] ALU_OP_LUI = 3'd2;
    localparam logic [2:0] ALU_OP_ADD = 3'd3;
    localparam logic [2:0] ALU_OP_BR  = 3'd4;

    // Reference bundle per opcode, as produced by the decoder.
    function automatic ctrl_t ctrl_for_opcode(input logic [6:0] op);
        ctrl_t c;
        case (op)
            OP_RTYPE:  c = {3'b001, 2'b00, 1'b0, ALU_OP_R};
            OP_ITYPE:  c = {3'b001, 2'b00, 1'b1, ALU_OP_I};
            OP_LUI:    c = {3'b001, 2'b00, 1'b1, ALU_OP_LUI};
            OP_LOAD:   c = {3'b011, 2'b10, 1'b1, ALU_OP_ADD};
            OP_STORE:  c = {3'b000, 2'b01, 1'b1, ALU_OP_ADD};
            OP_BRANCH: c = {3'b100, 2'b00, 1'b0, ALU_OP_BR};
            default:   c = CTRL_BUBBLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/control_pipe_stage_reg.sv
// One pipeline stage register holding a control bundle and its Rd.
// Ports: clk, rst_n (async low clear), bubble (sync zero load), ctrl_d/rd_d in, ctrl_q/rd_q out.
module ctrl_stage_reg
    import control_pipe_pkg::*;
#(
    parameter int unsigned RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            bubble,
    input  ctrl_t           ctrl_d,
    input  logic [RD_W-1:0] rd_d,
    output ctrl_t           ctrl_q,
    output logic [RD_W-1:0] rd_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= CTRL_BUBBLE;
            rd_q   <= '0;
        end else if (bubble) begin
            ctrl_q <= CTRL_BUBBLE;
            rd_q   <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            rd_q   <= rd_d;
        end
    end

endmodule

// File: rtl/control_pipe.sv
// Carries decode control bundles through ID/EX, EX/MEM and MEM/WB with stall/flush bubbles.
// Ports: clk, reset (async low), decode bits + Rd_i, Stall_i, Flush_i; EX_/MEM_/WB_ stage slices.
// Optional CONTROL_PIPE_PERF_EN adds Bubble_Count_o, a saturating stall/flush cycle counter.
module control_pipe
    import control_pipe_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
`ifdef CONTROL_PIPE_PERF_EN
    ,
    parameter int unsigned PERF_W = 16
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Branch_i,
    input  logic                  Mem_Read_i,
    input  logic                  Mem_to_Reg_i,
    input  logic                  Mem_Write_i,
    input  logic                  ALU_Src_i,
    input  logic                  Reg_Write_i,
    input  logic [2:0]            ALU_Op_i,
    input  logic [REG_ADDR_W-1:0] Rd_i,
    input  logic                  Stall_i,
    input  logic                  Flush_i,
    output logic                  EX_ALU_Src_o,
    output logic [2:0]            EX_ALU_Op_o,
    output logic                  EX_Mem_Read_o,
    output logic [REG_ADDR_W-1:0] EX_Rd_o,
    output logic                  MEM_Branch_o,
    output logic                  MEM_Mem_Read_o,
    output logic                  MEM_Mem_Write_o,
    output logic                  MEM_Reg_Write_o,
    output logic [REG_ADDR_W-1:0] MEM_Rd_o,
    output logic                  WB_Reg_Write_o,
    output logic                  WB_Mem_to_Reg_o,
    output logic [REG_ADDR_W-1:0] WB_Rd_o
`ifdef CONTROL_PIPE_PERF_EN
    ,
    output logic [PERF_W-1:0]     Bubble_Count_o
`endif
);

    ctrl_t                  dec_ctrl;
    ctrl_t                  idex_ctrl;
    ctrl_t                  exmem_ctrl;
    ctrl_t                  memwb_ctrl;
    logic [REG_ADDR_W-1:0]  idex_rd;
    logic [REG_ADDR_W-1:0]  exmem_rd;
    logic [REG_ADDR_W-1:0]  memwb_rd;
    logic                   wb_unused;

    // x0 is hardwired zero, so a write to it must never look like a write
    // to forwarding or writeback.
    always_comb begin
        dec_ctrl = {Branch_i, Mem_to_Reg_i, Reg_Write_i, Mem_Read_i,
                    Mem_Write_i, ALU_Src_i, ALU_Op_i};
        if (Rd_i == '0) begin
            dec_ctrl[CTRL_REG_WRITE] = 1'b0;
        end
    end

    // Flush dominates stall; either way ID/EX takes a bubble.
    ctrl_stage_reg #(.RD_W(REG_ADDR_W)) u_id_ex (
        .clk    (clk),
        .rst_n  (reset),
        .bubble (Stall_i | Flush_i),
        .ctrl_d (dec_ctrl),
        .rd_d   (Rd_i),
        .ctrl_q (idex_ctrl),
        .rd_q   (idex_rd)
    );

    ctrl_stage_reg #(.RD_W(REG_ADDR_W)) u_ex_mem (
        .clk    (clk),
        .rst_n  (reset),
        .bubble (Flush_i),
        .ctrl_d (idex_ctrl),
        .rd_d   (idex_rd),
        .ctrl_q (exmem_ctrl),
        .rd_q   (exmem_rd)
    );

    // The branch resolving in MEM retires even while it flushes younger work.
    ctrl_stage_reg #(.RD_W(REG_ADDR_W)) u_mem_wb (
        .clk    (clk),
        .rst_n  (reset),
        .bubble (1'b0),
        .ctrl_d (exmem_ctrl),
        .rd_d   (exmem_rd),
        .ctrl_q (memwb_ctrl),
        .rd_q   (memwb_rd)
    );

    assign EX_ALU_Src_o    = idex_ctrl[CTRL_ALU_SRC];
    assign EX_ALU_Op_o     = idex_ctrl[CTRL_ALUOP_MSB:CTRL_ALUOP_LSB];
    assign EX_Mem_Read_o   = idex_ctrl[CTRL_MEM_READ];
    assign EX_Rd_o         = idex_rd;

    assign MEM_Branch_o    = exmem_ctrl[CTRL_BRANCH];
    assign MEM_Mem_Read_o  = exmem_ctrl[CTRL_MEM_READ];
    assign MEM_Mem_Write_o = exmem_ctrl[CTRL_MEM_WRITE];
    assign MEM_Reg_Write_o = exmem_ctrl[CTRL_REG_WRITE];
    assign MEM_Rd_o        = exmem_rd;

    assign WB_Reg_Write_o  = memwb_ctrl[CTRL_REG_WRITE];
    assign WB_Mem_to_Reg_o = memwb_ctrl[CTRL_MEM_TO_REG];
    assign WB_Rd_o         = memwb_rd;

    // Bits that have no consumer once the bundle reaches writeback.
    assign wb_unused = ^{memwb_ctrl[CTRL_BRANCH], memwb_ctrl[CTRL_MEM_READ],
                         memwb_ctrl[CTRL_MEM_WRITE], memwb_ctrl[CTRL_ALU_SRC],
                         memwb_ctrl[CTRL_ALUOP_MSB:CTRL_ALUOP_LSB]};

`ifdef CONTROL_PIPE_PERF_EN
    logic [PERF_W-1:0] bubble_cnt;

    // Saturates so a long stall storm cannot wrap back to a small value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt <= '0;
        end else if ((Stall_i | Flush_i) && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    assign Bubble_Count_o = bubble_cnt;
`else
    // Default build: no bubble counter.
`endif

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe with a cycle-tagged expectation scoreboard.
// Expectations are queued as stimulus is issued and compared when their cycle arrives.
module tb_control_pipe;

    localparam int unsigned RW = 5;

    localparam logic [8:0] C_R  = 9'b001_00_0_000;
    localparam logic [8:0] C_I  = 9'b001_00_1_001;
    localparam logic [8:0] C_U  = 9'b001_00_1_010;
    localparam logic [8:0] C_LD = 9'b011_10_1_011;
    localparam logic [8:0] C_ST = 9'b000_01_1_011;
    localparam logic [8:0] C_BR = 9'b100_00_0_100;

    logic          clk = 1'b0;
    logic          reset;
    logic          Branch_i, Mem_Read_i, Mem_to_Reg_i, Mem_Write_i;
    logic          ALU_Src_i, Reg_Write_i;
    logic [2:0]    ALU_Op_i;
    logic [RW-1:0] Rd_i;
    logic          Stall_i, Flush_i;
    logic          EX_ALU_Src_o;
    logic [2:0]    EX_ALU_Op_o;
    logic          EX_Mem_Read_o;
    logic [RW-1:0] EX_Rd_o;
    logic          MEM_Branch_o, MEM_Mem_Read_o, MEM_Mem_Write_o, MEM_Reg_Write_o;
    logic [RW-1:0] MEM_Rd_o;
    logic          WB_Reg_Write_o, WB_Mem_to_Reg_o;
    logic [RW-1:0] WB_Rd_o;
`ifdef CONTROL_PIPE_PERF_EN
    logic [1:0]    Bubble_Count_o;
    logic [1:0]    bc_model = 2'b00;
`endif

    always #5 clk = ~clk;

    control_pipe #(
        .REG_ADDR_W (RW)
`ifdef CONTROL_PIPE_PERF_EN
        ,
        .PERF_W     (2)
`endif
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .Branch_i        (Branch_i),
        .Mem_Read_i      (Mem_Read_i),
        .Mem_to_Reg_i    (Mem_to_Reg_i),
        .Mem_Write_i     (Mem_Write_i),
        .ALU_Src_i       (ALU_Src_i),
        .Reg_Write_i     (Reg_Write_i),
        .ALU_Op_i        (ALU_Op_i),
        .Rd_i            (Rd_i),
        .Stall_i         (Stall_i),
        .Flush_i         (Flush_i),
        .EX_ALU_Src_o    (EX_ALU_Src_o),
        .EX_ALU_Op_o     (EX_ALU_Op_o),
        .EX_Mem_Read_o   (EX_Mem_Read_o),
        .EX_Rd_o         (EX_Rd_o),
        .MEM_Branch_o    (MEM_Branch_o),
        .MEM_Mem_Read_o  (MEM_Mem_Read_o),
        .MEM_Mem_Write_o (MEM_Mem_Write_o),
        .MEM_Reg_Write_o (MEM_Reg_Write_o),
        .MEM_Rd_o        (MEM_Rd_o),
        .WB_Reg_Write_o  (WB_Reg_Write_o),
        .WB_Mem_to_Reg_o (WB_Mem_to_Reg_o),
        .WB_Rd_o         (WB_Rd_o)
`ifdef CONTROL_PIPE_PERF_EN
        ,
        .Bubble_Count_o  (Bubble_Count_o)
`endif
    );

    typedef enum int {
        EX_SRC, EX_OP, EX_MR, EX_RD,
        MEM_BR, MEM_MR, MEM_MW, MEM_RW, MEM_RD,
        WB_RW, WB_MTR, WB_RD, ALL
    } sel_e;

    typedef struct {
        int          c;
        sel_e        s;
        logic [31:0] e;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] obs(input sel_e s);
        logic [31:0] v;
        case (s)
            EX_SRC:  v = 32'(EX_ALU_Src_o);
            EX_OP:   v = 32'(EX_ALU_Op_o);
            EX_MR:   v = 32'(EX_Mem_Read_o);
            EX_RD:   v = 32'(EX_Rd_o);
            MEM_BR:  v = 32'(MEM_Branch_o);
            MEM_MR:  v = 32'(MEM_Mem_Read_o);
            MEM_MW:  v = 32'(MEM_Mem_Write_o);
            MEM_RW:  v = 32'(MEM_Reg_Write_o);
            MEM_RD:  v = 32'(MEM_Rd_o);
            WB_RW:   v = 32'(WB_Reg_Write_o);
            WB_MTR:  v = 32'(WB_Mem_to_Reg_o);
            WB_RD:   v = 32'(WB_Rd_o);
            default: v = 32'({EX_ALU_Src_o, EX_ALU_Op_o, EX_Mem_Read_o, EX_Rd_o,
                              MEM_Branch_o, MEM_Mem_Read_o, MEM_Mem_Write_o,
                              MEM_Reg_Write_o, MEM_Rd_o,
                              WB_Reg_Write_o, WB_Mem_to_Reg_o, WB_Rd_o});
        endcase
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic push(input int c, input sel_e s, input logic [31:0] e);
        q.push_back('{c, s, e});
    endtask

    task automatic exp_ex(input int c, input logic [8:0] k, input logic [RW-1:0] rd);
        push(c, EX_SRC, 32'(k[3]));
        push(c, EX_OP,  32'(k[2:0]));
        push(c, EX_MR,  32'(k[5]));
        push(c, EX_RD,  32'(rd));
    endtask

    task automatic exp_mem(input int c, input logic [8:0] k, input logic [RW-1:0] rd);
        push(c, MEM_BR, 32'(k[8]));
        push(c, MEM_MR, 32'(k[5]));
        push(c, MEM_MW, 32'(k[4]));
        push(c, MEM_RW, 32'(k[6] && (rd != 0)));
        push(c, MEM_RD, 32'(rd));
    endtask

    task automatic exp_wb(input int c, input logic [8:0] k, input logic [RW-1:0] rd);
        push(c, WB_RW,  32'(k[6] && (rd != 0)));
        push(c, WB_MTR, 32'(k[7]));
        push(c, WB_RD,  32'(rd));
    endtask

    task automatic expect_instr(input logic [8:0] k, input logic [RW-1:0] rd);
        exp_ex(cyc + 1, k, rd);
        exp_mem(cyc + 2, k, rd);
        exp_wb(cyc + 3, k, rd);
    endtask

    task automatic check_due();
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].c == cyc) begin
                chk($sformatf("%s@%0d", q[i].s.name(), cyc), obs(q[i].s), q[i].e);
                q.delete(i);
            end
        end
    endtask

    task automatic drive(input logic [8:0] k, input logic [RW-1:0] rd,
                         input logic st, input logic fl);
        {Branch_i, Mem_to_Reg_i, Reg_Write_i, Mem_Read_i,
         Mem_Write_i, ALU_Src_i, ALU_Op_i} = k;
        Rd_i    = rd;
        Stall_i = st;
        Flush_i = fl;
    endtask

    task automatic tick();
`ifdef CONTROL_PIPE_PERF_EN
        if (reset && (Stall_i || Flush_i) && bc_model != 2'b11) bc_model++;
`endif
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_due();
    endtask

    task automatic issue(input logic [8:0] k, input logic [RW-1:0] rd);
        drive(k, rd, 1'b0, 1'b0);
        expect_instr(k, rd);
        tick();
    endtask

    task automatic stall_issue(input logic [8:0] k, input logic [RW-1:0] rd);
        drive(k, rd, 1'b1, 1'b0);
        expect_instr(9'b0, '0);
        tick();
    endtask

    task automatic ex_only_issue(input logic [8:0] k, input logic [RW-1:0] rd);
        drive(k, rd, 1'b0, 1'b0);
        exp_ex(cyc + 1, k, rd);
        tick();
    endtask

    // The decode item and the one in EX are both killed.
    task automatic flush_issue(input logic [8:0] k, input logic [RW-1:0] rd,
                               input logic st);
        drive(k, rd, st, 1'b1);
        exp_ex(cyc + 1, 9'b0, '0);
        exp_mem(cyc + 1, 9'b0, '0);
        exp_mem(cyc + 2, 9'b0, '0);
        exp_wb(cyc + 2, 9'b0, '0);
        exp_wb(cyc + 3, 9'b0, '0);
        tick();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            drive(9'b0, '0, 1'b0, 1'b0);
            tick();
        end
    endtask

    task automatic chk_perf(input string tag);
`ifdef CONTROL_PIPE_PERF_EN
        chk(tag, 32'(Bubble_Count_o), 32'(bc_model));
`else
        if (tag.len() == 0) $display("empty tag");
`endif
    endtask

    initial begin
        reset = 1'b0;
        drive(9'b0, '0, 1'b0, 1'b0);
        #1;
        chk("reset_all_zero", obs(ALL), 32'd0);
        chk_perf("reset_bubble_cnt");
        tick();
        tick();
        chk("reset_hold_zero", obs(ALL), 32'd0);
        reset = 1'b1;

        issue(C_R, 5'd5);
        issue(C_I, 5'd0);
        issue(C_LD, 5'd4);
        issue(C_ST, 5'd0);
        issue(C_BR, 5'd0);
        issue(C_R, 5'd31);
        issue(C_U, 5'd17);
        drain(3);

        issue(C_R, 5'd1);
        stall_issue(C_I, 5'd2);
        issue(C_U, 5'd3);
        drain(3);
        chk_perf("stall_bubble_cnt");

        issue(C_R, 5'd1);
        issue(C_R, 5'd2);
        ex_only_issue(C_R, 5'd3);
        flush_issue(C_R, 5'd4, 1'b0);
        issue(C_R, 5'd5);
        drain(3);
        chk_perf("flush_bubble_cnt");

        issue(C_R, 5'd1);
        issue(C_R, 5'd2);
        ex_only_issue(C_R, 5'd3);
        flush_issue(C_R, 5'd4, 1'b1);
        issue(C_R, 5'd5);
        drain(3);
        chk_perf("both_bubble_cnt");

        for (int i = 1; i <= 5; i++) stall_issue(C_R, 5'(i));
        drain(3);
        chk_perf("stall_sat_cnt");

        drive(C_R, 5'd7, 1'b0, 1'b0);
        tick();
        drive(C_LD, 5'd8, 1'b0, 1'b0);
        tick();
        drive(C_I, 5'd9, 1'b0, 1'b0);
        tick();
        chk("full_ex_rd", obs(EX_RD), 32'd9);
        chk("full_mem_rd", obs(MEM_RD), 32'd8);
        chk("full_wb_rd", obs(WB_RD), 32'd7);
        chk("full_wb_rw", obs(WB_RW), 32'd1);
        #2;
        reset = 1'b0;
`ifdef CONTROL_PIPE_PERF_EN
        bc_model = 2'b00;
`endif
        #1;
        chk("async_reset_zero", obs(ALL), 32'd0);
        chk_perf("async_reset_cnt");
        drive(C_R, 5'd10, 1'b1, 1'b0);
        tick();
        chk("reset_held_zero", obs(ALL), 32'd0);
        chk_perf("reset_held_cnt");
        reset = 1'b1;
        issue(C_R, 5'd12);
        drain(4);

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_pipe.md
Name: control_pipe

Overview:
- Receiving end of the decode control bundle in the 5-stage RISC-V pipeline.
- Captures the decoder's control signals and destination register each cycle and carries them through the ID/EX, EX/MEM and MEM/WB stage registers.
- Presents each stage's slice to the datapath, and implements bubble insertion (load-use stall) and flush (taken branch).

Parameters:
- REG_ADDR_W, 5, width of destination register index.
- PERF_W, 16, width of bubble counter (optional feature only).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Branch_i, Mem_Read_i, Mem_to_Reg_i, Mem_Write_i, ALU_Src_i, Reg_Write_i  input  1 each  decode control bits.
- ALU_Op_i  input  3  decode ALU operation class.
- Rd_i  input  REG_ADDR_W  decode destination register.
- Stall_i  input  1  load-use hazard; insert bubble into ID/EX.
- Flush_i  input  1  taken branch; kill ID/EX and EX/MEM contents.
- EX_ALU_Src_o  output  1  ID/EX slice.
- EX_ALU_Op_o  output  3  ID/EX slice.
- EX_Mem_Read_o  output  1  ID/EX slice, for the hazard unit.
- EX_Rd_o  output  REG_ADDR_W  ID/EX slice.
- MEM_Branch_o, MEM_Mem_Read_o, MEM_Mem_Write_o  output  1 each  EX/MEM slice.
- MEM_Reg_Write_o  output  1  EX/MEM slice, for forwarding.
- MEM_Rd_o  output  REG_ADDR_W  EX/MEM slice.
- WB_Reg_Write_o, WB_Mem_to_Reg_o  output  1 each  MEM/WB slice.
- WB_Rd_o  output  REG_ADDR_W  MEM/WB slice.

Behaviour:
- Internal bundle layout is 9 bits: [8] Branch, [7] Mem_to_Reg, [6] Reg_Write, [5] Mem_Read, [4] Mem_Write, [3] ALU_Src, [2:0] ALU_Op. A bundle travels with its Rd.
- Reset (reset==0, asynchronous): all three stage registers clear to 0, so every output is 0. The first capture happens on the first rising edge after reset deasserts.
- Normal advance, each rising edge: decode → ID/EX, ID/EX → EX/MEM, EX/MEM → MEM/WB.
  - Latency: decode to EX outputs 1 cycle, to MEM 2 cycles, to WB 3 cycles.
- x0 guard: if Rd_i==0, Reg_Write is forced to 0 at capture. Other bits are unaffected.
- Stall_i=1: ID/EX loads the all-zero bubble (Rd=0). EX/MEM and MEM/WB still advance. The upstream IF/ID hold is handled outside this block.
- Flush_i=1: ID/EX and EX/MEM load bubbles. MEM/WB still advances from the old EX/MEM, because the branch resolves in MEM and the instruction ahead of it must retire.
- Stall_i and Flush_i together: Flush wins; the result is identical to Flush alone.
- Bubble definition: all 9 bits 0 and Rd 0. A bubble never asserts Reg_Write, Mem_Write or Mem_Read.
- Only Reg_Write and Mem_Write carry architectural side effects. Datapath consumers ignore the other bits when those two are 0.
- Reset asserted mid-operation clears everything immediately, with no drain.
- Purely registered outputs: no combinational path from any input to any output.

Optional Feature:
- Macro: CONTROL_PIPE_PERF_EN.
- When defined:
  - adds output Bubble_Count_o (PERF_W bits).
  - Increments once per rising edge on which Stall_i or Flush_i is 1; a cycle with both counts once.
  - Saturates at all-ones and does not wrap.
  - Clears on reset.
- When undefined: the port and counter are absent, and all other behaviour is identical.

Decomposition:
- Shared package: CTRL_W=9, bit-index constants (CTRL_BRANCH=8 … CTRL_ALUOP_LSB=0), CTRL_BUBBLE=9'b0, and the opcode localparams shared with the decoder.
- One natural sub-module: ctrl_stage_reg, a CTRL_W+REG_ADDR_W register with async active-low clear and a synchronous bubble-load input. It is instantiated three times.

Test Plan:
- Reset then R-type bundle 9'b001_00_0_000, Rd=5: EX_ALU_Op_o=000 at +1; MEM_Reg_Write_o=1, MEM_Rd_o=5 at +2; WB_Reg_Write_o=1, WB_Rd_o=5 at +3.
- I-type logic 9'b001_00_1_001, Rd=0 → WB_Reg_Write_o=0 at +3 (x0 guard), with EX_ALU_Src_o=1 at +1.
- Back-to-back R-type Rd=1, I-type Rd=2, U-type Rd=3 with Stall_i=1 on the second edge → the sequence Rd 1, 0(bubble), 3 appears in turn on EX_Rd_o. Rd=2 is lost because no upstream hold is modelled in the bench.
- Stream Rd=1..4, then Flush_i=1 for one cycle when Rd=2 is in MEM → WB_Rd_o shows 2 next cycle. Rd=3 and 4 never reach MEM, and MEM_Reg_Write_o=0 for that cycle.
- Stall_i=1 and Flush_i=1 together → outputs match the flush-only run cycle for cycle. With CONTROL_PIPE_PERF_EN, Bubble_Count_o increments by 1.
- Assert reset mid-stream with all stages full → all outputs 0 within the same cycle, without a clock edge. With CONTROL_PIPE_PERF_EN and PERF_W=2: 5 stall cycles → Bubble_Count_o=3 (saturated).
